// File: rtl/m_spi_control.sv
// Mode-0 SPI master: one MSB-first word per SS assertion, with a start/done handshake
// toward on-chip logic. All four pin outputs come straight from flops.
`timescale 1ns/1ps
module m_spi_control #(
  parameter int DATA_LENGTH = 8,
  parameter int CLK_DIV     = 4,
  parameter int SS_GAP      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] tx_data,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   SCLK,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic                   SS
);

  localparam int PMAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int BW   = $clog2(DATA_LENGTH + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(SS_GAP - 1);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
  } state_t;

  state_t                 state, state_nxt;
  logic [PW-1:0]          phase, phase_nxt;
  logic [BW-1:0]          bitcnt, bitcnt_nxt;
  logic                   ss_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic                   load_tx, shift_tx, shift_rx, commit_rx;
  logic [DATA_LENGTH-1:0] tx_sh, rx_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= '0;
      bitcnt  <= '0;
      SS      <= 1'b1;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      bitcnt <= bitcnt_nxt;
      SS     <= ss_nxt;
      SCLK   <= sclk_nxt;
      MOSI   <= mosi_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      if (commit_rx) rx_data <= rx_sh;
    end
  end

  // Shift registers carry only data, so they need no reset.
  always_ff @(posedge clk) begin
    if (load_tx)       tx_sh <= tx_data;
    else if (shift_tx) tx_sh <= {tx_sh[DATA_LENGTH-2:0], 1'b0};
    if (shift_rx)      rx_sh <= {rx_sh[DATA_LENGTH-2:0], MISO};
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    bitcnt_nxt = bitcnt;
    ss_nxt     = SS;
    sclk_nxt   = SCLK;
    mosi_nxt   = MOSI;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    shift_rx   = 1'b0;
    commit_rx  = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = S_LOAD;
          load_tx   = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_LOAD: begin
        state_nxt  = S_SETUP;
        ss_nxt     = 1'b0;
        mosi_nxt   = tx_sh[DATA_LENGTH-1];
        phase_nxt  = '0;
        bitcnt_nxt = '0;
      end
      S_SETUP, S_LOW: begin
        if (phase == PH_LAST) begin
          state_nxt = S_HIGH;
          sclk_nxt  = 1'b1;
          shift_rx  = 1'b1;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_ONE;
        end
      end
      S_HIGH: begin
        if (phase == PH_LAST) begin
          sclk_nxt   = 1'b0;
          phase_nxt  = '0;
          bitcnt_nxt = bitcnt + BW'(1);
          // The final low phase doubles as the SS hold time; MOSI keeps the last bit.
          if (bitcnt == BIT_LAST) begin
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_LOW;
            mosi_nxt  = tx_sh[DATA_LENGTH-2];
            shift_tx  = 1'b1;
          end
        end else begin
          phase_nxt = phase + PH_ONE;
        end
      end
      S_HOLD: begin
        if (phase == PH_LAST) begin
          state_nxt = S_GAP;
          ss_nxt    = 1'b1;
          done_nxt  = 1'b1;
          commit_rx = 1'b1;
          phase_nxt = PH_ONE;
        end else begin
          phase_nxt = phase + PH_ONE;
        end
      end
      S_GAP: begin
        // Phase starts at 1 so a start in the last gap cycle gives exactly SS_GAP high cycles.
        if (phase >= GAP_LAST) begin
          if (start) begin
            state_nxt = S_LOAD;
            load_tx   = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
          end
        end else begin
          phase_nxt = phase + PH_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_m_spi_control.sv
// Bench for m_spi_control: mode-0 slave models on a default instance and a 16-bit/CLK_DIV=2
// instance, with expected words queued at stimulus time and compared when done fires.
`timescale 1ns/1ps
module tb_m_spi_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, a_busy, a_done, a_sclk, a_mosi, a_ss;
  logic        a_miso = 1'b0;
  logic [7:0]  a_tx, a_rx, a_sw;
  logic        b_start, b_busy, b_done, b_sclk, b_mosi, b_ss;
  logic        b_miso = 1'b0;
  logic [15:0] b_tx, b_rx, b_sw;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_rx_q[$];
  logic [15:0] exp_slv_q[$];

  m_spi_control u_a (
    .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx), .rx_data(a_rx),
    .busy(a_busy), .done(a_done), .SCLK(a_sclk), .MOSI(a_mosi), .MISO(a_miso), .SS(a_ss)
  );

  m_spi_control #(.DATA_LENGTH(16), .CLK_DIV(2), .SS_GAP(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx), .rx_data(b_rx),
    .busy(b_busy), .done(b_done), .SCLK(b_sclk), .MOSI(b_mosi), .MISO(b_miso), .SS(b_ss)
  );

  // Mode-0 slave for instance A, acting half a cycle after each pin change.
  logic [7:0] as_sh = '0, as_rx = '0, as_last = '0;
  int         as_bits = 0, as_words = 0;
  logic       as_pss = 1'b1, as_psclk = 1'b0;
  always @(negedge clk) begin
    if (as_pss && !a_ss) begin
      as_sh = a_sw; a_miso = as_sh[7]; as_bits = 0;
    end else if (!a_ss && a_sclk && !as_psclk) begin
      as_rx = {as_rx[6:0], a_mosi}; as_bits++;
    end else if (!a_ss && !a_sclk && as_psclk) begin
      as_sh = as_sh << 1; a_miso = as_sh[7];
    end
    if (a_ss && !as_pss && as_bits == 8) begin as_last = as_rx; as_words++; end
    if (a_ss) a_miso = 1'b0;
    as_pss = a_ss; as_psclk = a_sclk;
  end

  logic [15:0] bs_sh = '0, bs_rx = '0, bs_last = '0;
  int          bs_bits = 0, bs_words = 0;
  logic        bs_pss = 1'b1, bs_psclk = 1'b0;
  always @(negedge clk) begin
    if (bs_pss && !b_ss) begin
      bs_sh = b_sw; b_miso = bs_sh[15]; bs_bits = 0;
    end else if (!b_ss && b_sclk && !bs_psclk) begin
      bs_rx = {bs_rx[14:0], b_mosi}; bs_bits++;
    end else if (!b_ss && !b_sclk && bs_psclk) begin
      bs_sh = bs_sh << 1; b_miso = bs_sh[15];
    end
    if (b_ss && !bs_pss && bs_bits == 16) begin bs_last = bs_rx; bs_words++; end
    if (b_ss) b_miso = 1'b0;
    bs_pss = b_ss; bs_psclk = b_sclk;
  end

  // Pin activity monitor for instance A: SCLK edges, phase lengths, SS gap, done pulses.
  int   rise_cnt = 0, fr_rises = 0, bad_phase = 0, run_len = 0;
  int   gap_run = 0, last_gap = 0, done_cnt = 0;
  logic m_psclk = 1'b0, m_pss = 1'b1;
  always @(negedge clk) begin
    if (a_done) done_cnt++;
    if (m_pss && !a_ss) begin fr_rises = 0; last_gap = gap_run; end
    if (a_ss) gap_run++; else gap_run = 0;
    if (a_sclk && !m_psclk) begin
      if (fr_rises > 0 && run_len != 4) bad_phase++;
      fr_rises++; rise_cnt++; run_len = 1;
    end else if (!a_sclk && m_psclk) begin
      if (run_len != 4) bad_phase++;
      run_len = 1;
    end else begin
      run_len++;
    end
    m_psclk = a_sclk; m_pss = a_ss;
  end

  task automatic wait_done_a(input int budget, output int cyc);
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1; cyc++;
      if (a_done === 1'b1) return;
    end
    cyc = -1;
  endtask

  task automatic wait_done_b(input int budget, output int cyc);
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1; cyc++;
      if (b_done === 1'b1) return;
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    a_tx = '0; b_tx = '0; a_sw = '0; b_sw = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a_ss, a_sclk, a_mosi, a_busy, a_done} !== 5'b10000) begin
      bad++; $display("FAIL reset_pins got=%b want=10000", {a_ss, a_sclk, a_mosi, a_busy, a_done});
    end
    total++;
    if (a_rx !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h want=00", a_rx); end
    total++;
    if ({b_ss, b_sclk, b_busy, b_done} !== 4'b1000) begin
      bad++; $display("FAIL reset_b_pins got=%b want=1000", {b_ss, b_sclk, b_busy, b_done});
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    int cyc, r0, p0, w0;
    logic [15:0] e;
    @(negedge clk);
    a_tx = 8'hA5; a_sw = 8'h3C; a_start = 1'b1;
    exp_rx_q.push_back(16'h003C); exp_slv_q.push_back(16'h00A5);
    r0 = rise_cnt; p0 = bad_phase; w0 = as_words;
    @(posedge clk); #1 a_start = 1'b0;
    wait_done_a(200, cyc);
    total++;
    if (cyc != 69) begin bad++; $display("FAIL single_latency got=%0d want=69", cyc); end
    e = exp_rx_q.pop_front();
    total++;
    if (a_rx !== e[7:0]) begin bad++; $display("FAIL single_rx got=%h want=%h", a_rx, e[7:0]); end
    @(negedge clk); #1;
    e = exp_slv_q.pop_front();
    total++;
    if (as_words != w0 + 1 || as_last !== e[7:0]) begin
      bad++; $display("FAIL single_slave got=%h words=%0d want=%h", as_last, as_words - w0, e[7:0]);
    end
    total++;
    if (rise_cnt - r0 != 8) begin bad++; $display("FAIL single_rises got=%0d want=8", rise_cnt - r0); end
    total++;
    if (bad_phase - p0 != 0) begin bad++; $display("FAIL single_phase_len bad_phases=%0d want=0", bad_phase - p0); end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, d0, w0;
    logic [15:0] e;
    @(negedge clk);
    a_tx = 8'h01; a_sw = 8'h5A; a_start = 1'b1;
    exp_rx_q.push_back(16'h005A); exp_slv_q.push_back(16'h0001);
    exp_rx_q.push_back(16'h00E7); exp_slv_q.push_back(16'h0080);
    d0 = done_cnt; w0 = as_words;
    @(posedge clk); #1 a_tx = 8'h80;
    wait_done_a(200, cyc);
    total++;
    if (cyc != 69) begin bad++; $display("FAIL b2b_latency1 got=%0d want=69", cyc); end
    e = exp_rx_q.pop_front();
    total++;
    if (a_rx !== e[7:0]) begin bad++; $display("FAIL b2b_rx1 got=%h want=%h", a_rx, e[7:0]); end
    a_sw = 8'hE7;
    @(negedge clk); #1;
    e = exp_slv_q.pop_front();
    total++;
    if (as_last !== e[7:0]) begin bad++; $display("FAIL b2b_slave1 got=%h want=%h", as_last, e[7:0]); end
    @(posedge clk); #1 a_start = 1'b0;
    wait_done_a(200, cyc);
    total++;
    if (cyc != 69) begin bad++; $display("FAIL b2b_latency2 got=%0d want=69", cyc); end
    e = exp_rx_q.pop_front();
    total++;
    if (a_rx !== e[7:0]) begin bad++; $display("FAIL b2b_rx2 got=%h want=%h", a_rx, e[7:0]); end
    @(negedge clk); #1;
    e = exp_slv_q.pop_front();
    total++;
    if (as_last !== e[7:0] || as_words != w0 + 2) begin
      bad++; $display("FAIL b2b_slave2 got=%h words=%0d want=%h", as_last, as_words - w0, e[7:0]);
    end
    total++;
    if (last_gap != 2) begin bad++; $display("FAIL b2b_ss_gap got=%0d want=2", last_gap); end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", done_cnt - d0); end
  endtask

  task automatic test_busy_ignore();
    int cyc, d0;
    logic [15:0] e;
    @(negedge clk);
    a_tx = 8'h96; a_sw = 8'h69; a_start = 1'b1;
    exp_rx_q.push_back(16'h0069); exp_slv_q.push_back(16'h0096);
    d0 = done_cnt;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (20) @(posedge clk);
    #1 a_start = 1'b1; a_tx = 8'hFF;
    @(posedge clk); #1 a_start = 1'b0;
    wait_done_a(200, cyc);
    total++;
    if (cyc != 48) begin bad++; $display("FAIL busy_latency got=%0d want=48", cyc); end
    e = exp_rx_q.pop_front();
    total++;
    if (a_rx !== e[7:0]) begin bad++; $display("FAIL busy_rx got=%h want=%h", a_rx, e[7:0]); end
    @(negedge clk); #1;
    e = exp_slv_q.pop_front();
    total++;
    if (as_last !== e[7:0]) begin bad++; $display("FAIL busy_slave got=%h want=%h", as_last, e[7:0]); end
    repeat (100) @(posedge clk);
    #1;
    total++;
    if (done_cnt - d0 != 1 || a_ss !== 1'b1 || a_busy !== 1'b0) begin
      bad++; $display("FAIL busy_ignored dones=%0d ss=%b busy=%b want=1,1,0", done_cnt - d0, a_ss, a_busy);
    end
  endtask

  task automatic test_reset_midframe();
    int cyc, r0, d0, w0;
    bit found;
    logic [15:0] e;
    @(negedge clk);
    a_tx = 8'h5A; a_sw = 8'hC3; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    r0 = rise_cnt; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (rise_cnt - r0 >= 3) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL midrst_third_rise got=%0d want=3", rise_cnt - r0); end
    d0 = done_cnt; w0 = as_words;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({a_ss, a_sclk, a_mosi, a_busy, a_done} !== 5'b10000 || a_rx !== 8'h00) begin
      bad++; $display("FAIL midrst_async got=%b rx=%h want=10000 rx=00", {a_ss, a_sclk, a_mosi, a_busy, a_done}, a_rx);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a_ss, a_sclk, a_mosi, a_busy, a_done} !== 5'b10000 || a_rx !== 8'h00) begin
      bad++; $display("FAIL midrst_hold got=%b rx=%h want=10000 rx=00", {a_ss, a_sclk, a_mosi, a_busy, a_done}, a_rx);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt != d0 || as_words != w0) begin
      bad++; $display("FAIL midrst_no_done dones=%0d words=%0d want=0,0", done_cnt - d0, as_words - w0);
    end
    @(negedge clk);
    a_tx = 8'hFF; a_sw = 8'hA7; a_start = 1'b1;
    exp_rx_q.push_back(16'h00A7); exp_slv_q.push_back(16'h00FF);
    @(posedge clk); #1 a_start = 1'b0;
    wait_done_a(200, cyc);
    total++;
    if (cyc != 69) begin bad++; $display("FAIL midrst_latency got=%0d want=69", cyc); end
    e = exp_rx_q.pop_front();
    total++;
    if (a_rx !== e[7:0]) begin bad++; $display("FAIL midrst_rx got=%h want=%h", a_rx, e[7:0]); end
    @(negedge clk); #1;
    e = exp_slv_q.pop_front();
    total++;
    if (as_last !== e[7:0]) begin bad++; $display("FAIL midrst_slave got=%h want=%h", as_last, e[7:0]); end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_param_sweep();
    int cyc, w0;
    logic [15:0] e;
    @(negedge clk);
    b_tx = 16'hC3A5; b_sw = 16'h5A3C; b_start = 1'b1;
    exp_rx_q.push_back(16'h5A3C); exp_slv_q.push_back(16'hC3A5);
    w0 = bs_words;
    @(posedge clk); #1 b_start = 1'b0;
    wait_done_b(200, cyc);
    total++;
    if (cyc != 67) begin bad++; $display("FAIL sweep_latency got=%0d want=67", cyc); end
    e = exp_rx_q.pop_front();
    total++;
    if (b_rx !== e) begin bad++; $display("FAIL sweep_rx got=%h want=%h", b_rx, e); end
    @(negedge clk); #1;
    e = exp_slv_q.pop_front();
    total++;
    if (bs_last !== e || bs_words != w0 + 1) begin
      bad++; $display("FAIL sweep_slave got=%h words=%0d want=%h", bs_last, bs_words - w0, e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
